// File: rtl/filter_sequencer.sv
// Frame sequencer for the 12th-order all-pole synthesis filter: loads coefficient
// frames while the filter is idle, then feeds one excitation sample per tick.
module filter_sequencer #(
  parameter int NCOEF = 12,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       cw_data,
  input  logic [LEN_W-1:0] cw_len,
  input  logic             cw_valid,
  output logic             cw_ready,
  input  logic [15:0]      src_in,
  input  logic             tick,
  output logic [9:0]       f_coef,
  output logic             f_coef_load,
  output logic [15:0]      f_sig_in,
  output logic             f_start,
  input  logic             f_done,
  input  logic [15:0]      f_sig_out,
  output logic [15:0]      pcm_out,
  output logic             pcm_valid,
  output logic             missed_tick,
  output logic             underrun,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(NCOEF + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NCOEF - 1);
  localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(NCOEF);
  localparam logic [LEN_W:0]   ONE_LEFT  = (LEN_W+1)'(1);

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, SETTLE = 2'd2, WAIT = 2'd3} state_t;

  // cw handshake: a word transfers on a rising edge where cw_valid & cw_ready are both high.
  state_t           r_state;
  logic [CNT_W-1:0] r_word_cnt;
  logic [LEN_W:0]   r_samp_cnt;
  logic             r_settle;
  logic             r_first_load;
  logic             r_cw_ready;
  logic [9:0]       r_coef;
  logic             r_coef_load;
  logic [15:0]      r_sig_in;
  logic             r_start;
  logic [15:0]      r_pcm;
  logic             r_pcm_valid;
  logic             r_missed;
  logic             r_underrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD;
      r_word_cnt   <= '0;
      r_samp_cnt   <= '0;
      r_settle     <= 1'b0;
      r_first_load <= 1'b0;
      r_cw_ready   <= 1'b0;
      r_coef       <= '0;
      r_coef_load  <= 1'b0;
      r_sig_in     <= '0;
      r_start      <= 1'b0;
      r_pcm        <= '0;
      r_pcm_valid  <= 1'b0;
      r_missed     <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_coef_load <= 1'b0;
      r_start     <= 1'b0;
      r_pcm_valid <= 1'b0;
      r_missed    <= 1'b0;
      r_underrun  <= 1'b0;
      case (r_state)
        LOAD: begin
          r_first_load <= 1'b0;
          if (r_first_load && !cw_valid) r_underrun <= 1'b1;
          if (tick) r_missed <= 1'b1;
          // Stay one extra cycle after the last accept so the final load pulse lands in LOAD.
          if (r_word_cnt == ALL_WORDS) begin
            r_state <= RUN;
          end else if (cw_valid && r_cw_ready) begin
            r_coef      <= cw_data;
            r_coef_load <= 1'b1;
            r_word_cnt  <= r_word_cnt + 1'b1;
            if (r_word_cnt == '0)
              r_samp_cnt <= (cw_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cw_len};
            r_cw_ready <= (r_word_cnt != LAST_WORD);
          end else begin
            r_cw_ready <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            if (f_done) begin
              r_sig_in <= src_in;
              r_start  <= 1'b1;
              r_settle <= 1'b0;
              r_state  <= SETTLE;
            end else begin
              r_missed <= 1'b1;
            end
          end
        end
        SETTLE: begin
          // The filter still shows done for one cycle after taking start; ignore it.
          if (tick) r_missed <= 1'b1;
          if (r_settle) r_state <= WAIT;
          else r_settle <= 1'b1;
        end
        WAIT: begin
          if (tick) r_missed <= 1'b1;
          if (f_done) begin
            r_pcm       <= f_sig_out;
            r_pcm_valid <= 1'b1;
            r_samp_cnt  <= r_samp_cnt - 1'b1;
            if (r_samp_cnt == ONE_LEFT) begin
              r_state      <= LOAD;
              r_word_cnt   <= '0;
              r_cw_ready   <= 1'b1;
              r_first_load <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign cw_ready    = r_cw_ready;
  assign f_coef      = r_coef;
  assign f_coef_load = r_coef_load;
  assign f_sig_in    = r_sig_in;
  assign f_start     = r_start;
  assign pcm_out     = r_pcm;
  assign pcm_valid   = r_pcm_valid;
  assign missed_tick = r_missed;
  assign underrun    = r_underrun;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_filter_sequencer.sv
// Directed bench for filter_sequencer with a behavioural zero-coefficient filter
// (output = input after a fixed compute time) and queue-based scoreboards.
module tb_filter_sequencer;

  localparam int COMP = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  cw_data = '0;
  logic [7:0]  cw_len = '0;
  logic        cw_valid = 1'b0;
  logic        cw_ready;
  logic [15:0] src_in = '0;
  logic        tick = 1'b0;
  logic [9:0]  f_coef;
  logic        f_coef_load;
  logic [15:0] f_sig_in;
  logic        f_start;
  logic        f_done;
  logic [15:0] f_sig_out;
  logic [15:0] pcm_out;
  logic        pcm_valid;
  logic        missed_tick;
  logic        underrun;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [9:0]  coef_q[$];
  int cyc = 0, load_cnt = 0, first_load_cyc = 0, last_load_cyc = 0;
  int start_cnt = 0, pcm_cnt = 0, missed_cnt = 0, under_cnt = 0;

  filter_sequencer #(.NCOEF(12), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .cw_data(cw_data), .cw_len(cw_len), .cw_valid(cw_valid),
    .cw_ready(cw_ready), .src_in(src_in), .tick(tick), .f_coef(f_coef),
    .f_coef_load(f_coef_load), .f_sig_in(f_sig_in), .f_start(f_start), .f_done(f_done),
    .f_sig_out(f_sig_out), .pcm_out(pcm_out), .pcm_valid(pcm_valid),
    .missed_tick(missed_tick), .underrun(underrun), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Filter model: done stays high one cycle after start, low for COMP cycles, then result.
  int fcnt = 0;
  logic [15:0] f_lat = '0;
  logic [15:0] f_out = '0;
  assign f_done = (fcnt == 0) || (fcnt == COMP + 1);
  assign f_sig_out = f_out;
  always @(negedge clk) begin
    if (rst) begin
      fcnt = 0;
    end else if (f_start) begin
      f_lat = f_sig_in;
      fcnt = COMP + 1;
    end else if (fcnt > 0) begin
      fcnt--;
      if (fcnt == 0) f_out = f_lat;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (f_coef_load) begin
        if (load_cnt == 0) first_load_cyc = cyc;
        last_load_cyc = cyc;
        load_cnt++;
        check("load_in_load_state", dbg_state, 0);
        check("coef_expected", (coef_q.size() != 0), 1);
        if (coef_q.size() != 0) check("coef_value", f_coef, coef_q.pop_front());
      end
      if (f_start) begin
        start_cnt++;
        if (exp_q.size() != 0) check("sig_in_value", f_sig_in, exp_q[0]);
      end
      if (pcm_valid) begin
        pcm_cnt++;
        check("pcm_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("pcm_value", pcm_out, exp_q.pop_front());
      end
      if (missed_tick) missed_cnt++;
      if (underrun) under_cnt++;
    end
  end

  // Driver tasks (called at a falling edge, return at a falling edge)
  task automatic send_frame(input logic [7:0] len, input logic [9:0] base, input logic [9:0] step);
    for (int i = 0; i < 12; i++) begin
      int t;
      cw_valid = 1'b1;
      cw_data  = 10'(base + step * i);
      cw_len   = len;
      t = 0;
      while (!cw_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("cw_ready_wait", (t < 200), 1);
      coef_q.push_back(cw_data);
      @(negedge clk);
    end
    cw_valid = 1'b0;
  endtask

  task automatic do_tick(input logic [15:0] v, input bit accept);
    tick   = 1'b1;
    src_in = v;
    if (accept) exp_q.push_back(v);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int b_start, b_pcm, b_missed, b_under, t;

    // Reset values
    wait_cycles(3);
    #1;
    check("rst_cw_ready", cw_ready, 0);
    check("rst_f_coef_load", f_coef_load, 0);
    check("rst_f_start", f_start, 0);
    check("rst_pcm_valid", pcm_valid, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_first_cycle", cw_ready, 0);
    @(negedge clk);
    check("ready_second_cycle", cw_ready, 1);

    // Back-to-back frame 0x001..0x00C, length 3
    load_cnt = 0;
    send_frame(8'd3, 10'd1, 10'd1);
    wait_cycles(3);
    check("load_count", load_cnt, 12);
    check("load_consecutive", last_load_cyc - first_load_cyc, 11);
    check("ready_low_after_load", cw_ready, 0);
    check("state_run", dbg_state, 1);

    // Three well-spaced samples, frame exhausts with no new frame
    do_tick(16'h1000, 1'b1); wait_cycles(199);
    do_tick(16'hF00D, 1'b1); wait_cycles(199);
    do_tick(16'h1000, 1'b1); wait_cycles(199);
    check("pcm_count_3", pcm_cnt, 3);
    check("start_count_3", start_cnt, 3);
    check("missed_none", missed_cnt, 0);
    check("ready_after_frame", cw_ready, 1);
    check("underrun_once", under_cnt, 1);
    check("pcm_out_hold", pcm_out, 16'h1000);

    // Tick while waiting for a frame is dropped
    do_tick(16'h2222, 1'b0);
    wait_cycles(5);
    check("load_tick_missed", missed_cnt, 1);
    check("load_tick_no_start", start_cnt, 3);
    check("underrun_single", under_cnt, 1);

    // Length 0 means 256 samples
    send_frame(8'd0, 10'd0, 10'd0);
    wait_cycles(3);
    b_pcm = pcm_cnt;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        check("len0_pcm_before_last", pcm_cnt - b_pcm, 255);
        check("len0_ready_before_last", cw_ready, 0);
      end
      do_tick(16'($urandom_range(0, 65535)), 1'b1);
      wait_cycles(28);
    end
    wait_cycles(40);
    check("len0_pcm_count", pcm_cnt - b_pcm, 256);
    check("len0_ready_after", cw_ready, 1);
    check("len0_underrun", under_cnt, 2);

    // Two ticks 10 cycles apart, then next frame supplied before exhaustion
    send_frame(8'd2, 10'h200, 10'd3);
    wait_cycles(3);
    b_start = start_cnt; b_pcm = pcm_cnt; b_missed = missed_cnt; b_under = under_cnt;
    do_tick(16'h1234, 1'b1);
    wait_cycles(9);
    do_tick(16'h5555, 1'b0);
    wait_cycles(40);
    check("close_ticks_start", start_cnt - b_start, 1);
    check("close_ticks_missed", missed_cnt - b_missed, 1);
    check("close_ticks_pcm", pcm_cnt - b_pcm, 1);
    do_tick(16'h0F0F, 1'b1);
    send_frame(8'd1, 10'h3FF, 10'h3FF);
    wait_cycles(3);
    check("no_underrun_when_ready", under_cnt, b_under);
    check("pcm_after_second", pcm_cnt - b_pcm, 2);
    check("state_run_again", dbg_state, 1);

    // Asynchronous reset during WAIT
    do_tick(16'h4321, 1'b1);
    t = 0;
    while (dbg_state != 2'd3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("reach_wait", dbg_state, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_state", dbg_state, 0);
    check("arst_pcm_out", pcm_out, 0);
    check("arst_f_coef", f_coef, 0);
    check("arst_f_sig_in", f_sig_in, 0);
    check("arst_cw_ready", cw_ready, 0);
    check("arst_strobes", {pcm_valid, missed_tick, underrun, f_start, f_coef_load}, 0);
    exp_q.delete();
    coef_q.delete();
    wait_cycles(2);
    rst = 1'b0;
    @(negedge clk);
    load_cnt = 0;
    send_frame(8'd1, 10'h155, 10'h021);
    wait_cycles(3);
    check("reload_count", load_cnt, 12);
    check("reload_consecutive", last_load_cyc - first_load_cyc, 11);
    check("reload_state_run", dbg_state, 1);
    b_under = under_cnt;
    do_tick(16'hBEEF, 1'b1);
    wait_cycles(40);
    check("reload_pcm_out", pcm_out, 16'hBEEF);
    check("reload_underrun", under_cnt - b_under, 1);
    check("exp_q_drained", exp_q.size(), 0);
    check("coef_q_drained", coef_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
